// File: rtl/fifo_sync_ctrl.sv
// rtl/fifo_sync_ctrl.sv - single-clock FIFO pointer/flag controller
// Owns read/write pointers, occupancy count, threshold flags and sticky error flags.
module fifo_sync_ctrl #(
  parameter int PTR_WIDTH = 5,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2
) (
  input  logic                 clk_i,
  input  logic                 nrst_i,
  input  logic                 w_en_i,
  input  logic                 r_en_i,
  input  logic                 flush_i,
  input  logic                 clr_err_i,
  output logic [PTR_WIDTH-1:0] w_ptr_o,
  output logic [PTR_WIDTH-1:0] r_ptr_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH-1:0] count_o,
  output logic                 overflow_o,
  output logic                 underflow_o
);

  localparam int AW = PTR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] ONE = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [PTR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [PTR_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic full, empty, wr_ok, rd_ok;

  // Flags come straight off the registered pointers so the storage array sees them with no extra lag.
  assign empty = (w_ptr_q == r_ptr_q);
  assign full  = (w_ptr_q[AW] != r_ptr_q[AW]) && (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);
  assign wr_ok = w_en_i && !full;
  assign rd_ok = r_en_i && !empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    if (flush_i) begin
      // Discard everything, including a write landing on this same edge.
      r_ptr_d = w_ptr_q;
      count_d = '0;
    end else begin
      if (wr_ok) w_ptr_d = w_ptr_q + ONE;
      if (rd_ok) r_ptr_d = r_ptr_q + ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // A new offence in the clearing cycle keeps the flag set.
  always_comb begin
    overflow_d  = (overflow_q  && !clr_err_i) || (w_en_i && full);
    underflow_d = (underflow_q && !clr_err_i) || (r_en_i && empty);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign w_ptr_o        = w_ptr_q;
  assign r_ptr_o        = r_ptr_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= PTR_WIDTH'(AF_LEVEL));
  assign almost_empty_o = (count_q <= PTR_WIDTH'(AE_LEVEL));
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb/tb_fifo_sync_ctrl.sv - self-checking bench for fifo_sync_ctrl
module tb_fifo_sync_ctrl;
  localparam int PW = 5;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic nrst, w_en, r_en, flush, clr_err;
  logic [PW-1:0] w_ptr, r_ptr, count;
  logic full, empty, afull, aempty, ovf, unf;

  fifo_sync_ctrl #(.PTR_WIDTH(PW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk_i(clk), .nrst_i(nrst), .w_en_i(w_en), .r_en_i(r_en), .flush_i(flush),
    .clr_err_i(clr_err), .w_ptr_o(w_ptr), .r_ptr_o(r_ptr), .full_o(full),
    .empty_o(empty), .almost_full_o(afull), .almost_empty_o(aempty),
    .count_o(count), .overflow_o(ovf), .underflow_o(unf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference: occupancy and free-running write/read counts, storage as an array, contents as a queue.
  int m_cnt, m_wp, m_rp;
  bit m_ovf, m_unf;
  int mem [DEPTH];
  int q [$];
  int next_data = 1;

  typedef struct {
    bit w; bit r; bit f; bit c;
    int cnt; bit e; bit fu; bit ov; bit un;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
    q.delete();
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, int'(count), m_cnt);
    chk({tag, ".w_ptr"}, int'(w_ptr), m_wp % 32);
    chk({tag, ".r_ptr"}, int'(r_ptr), m_rp % 32);
    chk({tag, ".full"}, int'(full), int'(m_cnt == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(m_cnt == 0));
    chk({tag, ".afull"}, int'(afull), int'(m_cnt >= AF));
    chk({tag, ".aempty"}, int'(aempty), int'(m_cnt <= AE));
    chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
    chk({tag, ".unf"}, int'(unf), int'(m_unf));
    chk({tag, ".invariant"}, int'(count), (int'(w_ptr) - int'(r_ptr) + 32) % 32);
  endtask

  task automatic cycle(input bit w, input bit r, input bit f, input bit c, input string tag);
    bit m_full, m_empty, wr_ok, rd_ok;
    @(negedge clk);
    w_en = w; r_en = r; flush = f; clr_err = c;
    m_full = (m_cnt == DEPTH);
    m_empty = (m_cnt == 0);
    wr_ok = w && !m_full;
    rd_ok = r && !m_empty;
    if (rd_ok && !f) begin
      if (q.size() > 0) begin
        chk({tag, ".rdata"}, mem[r_ptr[3:0]], q[0]);
        void'(q.pop_front());
      end else begin
        chk({tag, ".model_q"}, 0, 1);
      end
    end
    if (wr_ok) begin
      mem[w_ptr[3:0]] = next_data;
      if (!f) q.push_back(next_data);
      next_data++;
    end
    if (f) begin
      m_rp = m_wp; m_cnt = 0; q.delete();
    end else begin
      if (wr_ok) m_wp = (m_wp + 1) % 32;
      if (rd_ok) m_rp = (m_rp + 1) % 32;
      m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
    end
    m_ovf = (m_ovf && !c) || (w && m_full);
    m_unf = (m_unf && !c) || (r && m_empty);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    int start, toggles, prev_msb, rp0, wp0;
    nrst = 1'b0; w_en = 0; r_en = 0; flush = 0; clr_err = 0;
    model_reset();

    vecs[0]  = '{w:0, r:1, f:0, c:0, cnt:0, e:1, fu:0, ov:0, un:1};
    vecs[1]  = '{w:1, r:0, f:0, c:0, cnt:1, e:0, fu:0, ov:0, un:1};
    vecs[2]  = '{w:1, r:1, f:0, c:0, cnt:1, e:0, fu:0, ov:0, un:1};
    vecs[3]  = '{w:0, r:0, f:0, c:1, cnt:1, e:0, fu:0, ov:0, un:0};
    vecs[4]  = '{w:1, r:0, f:0, c:0, cnt:2, e:0, fu:0, ov:0, un:0};
    vecs[5]  = '{w:1, r:0, f:0, c:0, cnt:3, e:0, fu:0, ov:0, un:0};
    vecs[6]  = '{w:0, r:1, f:0, c:0, cnt:2, e:0, fu:0, ov:0, un:0};
    vecs[7]  = '{w:1, r:0, f:1, c:0, cnt:0, e:1, fu:0, ov:0, un:0};
    vecs[8]  = '{w:1, r:1, f:0, c:0, cnt:1, e:0, fu:0, ov:0, un:1};
    vecs[9]  = '{w:0, r:1, f:0, c:1, cnt:0, e:1, fu:0, ov:0, un:0};
    vecs[10] = '{w:0, r:1, f:0, c:1, cnt:0, e:1, fu:0, ov:0, un:1};

    #12;
    chk("reset.count", int'(count), 0);
    chk("reset.empty", int'(empty), 1);
    chk("reset.full", int'(full), 0);
    chk("reset.aempty", int'(aempty), 1);
    chk("reset.afull", int'(afull), 0);
    chk("reset.ptrs", int'(w_ptr) + int'(r_ptr), 0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].w, vecs[i].r, vecs[i].f, vecs[i].c, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tcount", i), int'(count), vecs[i].cnt);
      chk($sformatf("vec%0d.tempty", i), int'(empty), int'(vecs[i].e));
      chk($sformatf("vec%0d.tfull", i), int'(full), int'(vecs[i].fu));
      chk($sformatf("vec%0d.tovf", i), int'(ovf), int'(vecs[i].ov));
      chk($sformatf("vec%0d.tunf", i), int'(unf), int'(vecs[i].un));
    end

    // fill to full, then simultaneous read/write at full, then drain
    cycle(0, 0, 0, 1, "clr");
    for (int i = 1; i <= 16; i++) begin
      cycle(1, 0, 0, 0, "fill");
      chk("fill.count", int'(count), i);
      chk("fill.afull", int'(afull), int'(i >= 12));
      chk("fill.full", int'(full), int'(i == 16));
    end
    wp0 = int'(w_ptr); rp0 = int'(r_ptr);
    cycle(1, 1, 0, 0, "atfull");
    chk("atfull.count", int'(count), 15);
    chk("atfull.ovf", int'(ovf), 1);
    chk("atfull.wptr_hold", int'(w_ptr), wp0);
    chk("atfull.rptr_adv", int'(r_ptr), (rp0 + 1) % 32);
    for (int i = 14; i >= 0; i--) begin
      cycle(0, 1, 0, 0, "drain");
      chk("drain.count", int'(count), i);
      chk("drain.aempty", int'(aempty), int'(i <= 2));
    end
    chk("drain.empty", int'(empty), 1);
    wp0 = int'(w_ptr);
    cycle(1, 1, 0, 1, "atempty");
    chk("atempty.count", int'(count), 1);
    chk("atempty.unf", int'(unf), 1);
    chk("atempty.wptr_adv", int'(w_ptr), (wp0 + 1) % 32);

    // sticky underflow
    cycle(0, 1, 0, 1, "stk_clr_rd");
    chk("stk.unf_set", int'(unf), 0);
    cycle(0, 1, 0, 0, "stk_set");
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, "stk_idle");
    chk("stk.unf_held", int'(unf), 1);
    cycle(0, 0, 0, 1, "stk_clr");
    chk("stk.unf_clr", int'(unf), 0);
    cycle(0, 1, 0, 1, "stk_setwins");
    chk("stk.setwins", int'(unf), 1);

    // wrap-around at COUNT=3
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, "wrap_pre");
    start = m_wp; toggles = 0; prev_msb = int'(w_ptr[4]);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 0, 0, "wrap");
      chk("wrap.count", int'(count), 3);
      chk("wrap.flags", int'(full) + int'(empty), 0);
      if (int'(w_ptr[4]) != prev_msb) toggles++;
      prev_msb = int'(w_ptr[4]);
    end
    chk("wrap.toggles", toggles, (start + 40) / 16 - start / 16);

    // flush at COUNT=9 with a write on the same edge
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, "flush_pre");
    chk("flush_pre.count", int'(count), 9);
    cycle(1, 0, 1, 0, "flush");
    chk("flush.empty", int'(empty), 1);
    chk("flush.count", int'(count), 0);
    chk("flush.ptr_eq", int'(r_ptr), int'(w_ptr));
    chk("flush.unf_kept", int'(unf), 1);
    chk("flush.ovf_kept", int'(ovf), 0);

    // asynchronous reset mid-stream at COUNT=7
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, "ar_pre");
    w_en = 0; r_en = 0; flush = 0; clr_err = 0;
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("areset.w_ptr", int'(w_ptr), 0);
    chk("areset.r_ptr", int'(r_ptr), 0);
    chk("areset.empty", int'(empty), 1);
    chk("areset.count", int'(count), 0);
    chk("areset.unf", int'(unf), 0);
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
    cycle(1, 0, 0, 0, "ar_resume");
    cycle(0, 1, 0, 0, "ar_resume");

    // randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 300) % 3;
      cycle(($urandom_range(0, 9) < (mode == 0 ? 7 : (mode == 1 ? 3 : 5))),
            ($urandom_range(0, 9) < (mode == 0 ? 3 : (mode == 1 ? 7 : 5))),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
